// File: rtl/uop_pkg.sv
// Shared definitions for the micro-op sequencer: FSM states, opcodes, micro-op word layout.
package uop_pkg;

    localparam int unsigned REG_W     = 3;
    localparam int unsigned OP_W      = 4;
    localparam int unsigned SEL_W     = 3;
    localparam int unsigned UOP_W     = 14;

    localparam int unsigned SRC1_LSB  = 0;
    localparam int unsigned SRC2_LSB  = 3;
    localparam int unsigned DEST_LSB  = 6;
    localparam int unsigned OP_LSB    = 9;
    localparam int unsigned LAST_BIT  = 13;

    localparam int unsigned NUM_PROGS = 2;

    localparam logic [OP_W-1:0] OP_ADD = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB = 4'h1;
    localparam logic [OP_W-1:0] OP_AND = 4'h2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        ISSUE  = 3'd2,
        WAIT   = 3'd3,
        FINISH = 3'd4
    } state_t;

    // Packs one ROM word as {last, opcode, dest, src2, src1}.
    function automatic logic [UOP_W-1:0] make_uop(
        input logic             last,
        input logic [OP_W-1:0]  op,
        input logic [REG_W-1:0] dest,
        input logic [REG_W-1:0] src2,
        input logic [REG_W-1:0] src1
    );
        return {last, op, dest, src2, src1};
    endfunction

    function automatic logic sel_valid(input logic [SEL_W-1:0] sel);
        return 32'(sel) < NUM_PROGS;
    endfunction

endpackage

// File: rtl/micro_rom.sv
// Registered case-table micro-op program store, addressed by selector and step.
import uop_pkg::*;

module micro_rom #(
    parameter int unsigned STEP_W = 2
) (
    input  logic              clk,
    input  logic [SEL_W-1:0]  sel,
    input  logic [STEP_W-1:0] step,
    output logic [UOP_W-1:0]  word,
    output logic              valid
);

    always_ff @(posedge clk) begin
        valid <= sel_valid(sel);
        word  <= '0;
        case (sel)
            3'd0: begin
                if (step == STEP_W'(0))
                    word <= make_uop(1'b1, OP_ADD, 3'd3, 3'd2, 3'd1);
            end
            3'd1: begin
                if (step == STEP_W'(0))
                    word <= make_uop(1'b0, OP_SUB, 3'd4, 3'd2, 3'd1);
                else if (step == STEP_W'(1))
                    word <= make_uop(1'b1, OP_AND, 3'd5, 3'd3, 3'd4);
            end
            default: word <= '0;
        endcase
    end

endmodule

// File: rtl/micro_sequencer.sv
// Steps through a stored micro-op program, issuing one WR strobe per step and
// waiting for DONE from the data path before advancing.
import uop_pkg::*;

module micro_sequencer #(
    parameter int unsigned MAX_STEPS = 4,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SEL_W-1:0] c,
    input  logic             DONE,
    output logic [REG_W-1:0] src1,
    output logic [REG_W-1:0] src2,
    output logic [REG_W-1:0] dest,
    output logic [OP_W-1:0]  opcode,
    output logic             WR,
    output logic             busy,
    output logic             finished,
    output logic             error
);

    localparam int unsigned STEP_W = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
    localparam int unsigned WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t              state;
    logic [SEL_W-1:0]    sel_q;
    logic [STEP_W-1:0]   step_q;
    logic [WCNT_W-1:0]   wcnt;
    logic                last_q;

    logic [SEL_W-1:0]    rom_sel_c;
    logic [STEP_W-1:0]   rom_step_c;
    logic [UOP_W-1:0]    rom_word;
    logic                rom_valid;
    logic                prog_end_c;
    logic                advance_c;

    // ROM is addressed with next-cycle selector/step so the word is ready in FETCH.
    always_comb begin
        prog_end_c = last_q || (step_q == STEP_W'(MAX_STEPS - 1));
        advance_c  = ((state == ISSUE) || (state == WAIT)) && DONE && !prog_end_c;
        rom_sel_c  = sel_q;
        rom_step_c = step_q;
        if ((state == IDLE) && start) begin
            rom_sel_c  = c;
            rom_step_c = '0;
        end else if (advance_c) begin
            rom_step_c = step_q + STEP_W'(1);
        end
    end

    micro_rom #(
        .STEP_W (STEP_W)
    ) u_rom (
        .clk   (clk),
        .sel   (rom_sel_c),
        .step  (rom_step_c),
        .word  (rom_word),
        .valid (rom_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sel_q    <= '0;
            step_q   <= '0;
            wcnt     <= '0;
            last_q   <= 1'b0;
            src1     <= '0;
            src2     <= '0;
            dest     <= '0;
            opcode   <= '0;
            WR       <= 1'b0;
            busy     <= 1'b0;
            finished <= 1'b0;
            error    <= 1'b0;
        end else begin
            sel_q    <= rom_sel_c;
            step_q   <= rom_step_c;
            WR       <= 1'b0;
            finished <= 1'b0;
            error    <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        if (sel_valid(c)) begin
                            state <= FETCH;
                            busy  <= 1'b1;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end

                FETCH: begin
                    if (rom_valid) begin
                        state  <= ISSUE;
                        WR     <= 1'b1;
                        src1   <= rom_word[SRC1_LSB +: REG_W];
                        src2   <= rom_word[SRC2_LSB +: REG_W];
                        dest   <= rom_word[DEST_LSB +: REG_W];
                        opcode <= rom_word[OP_LSB +: OP_W];
                        last_q <= rom_word[LAST_BIT];
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end
                end

                ISSUE: begin
                    wcnt <= '0;
                    if (DONE) begin
                        if (prog_end_c) begin
                            state    <= FINISH;
                            finished <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end else begin
                        state <= WAIT;
                    end
                end

                WAIT: begin
                    if (DONE) begin
                        if (prog_end_c) begin
                            state    <= FINISH;
                            finished <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end else if (wcnt == WCNT_W'(TIMEOUT - 1)) begin
                        // No DONE within the budget: abandon the program.
                        state  <= IDLE;
                        busy   <= 1'b0;
                        error  <= 1'b1;
                        src1   <= '0;
                        src2   <= '0;
                        dest   <= '0;
                        opcode <= '0;
                        last_q <= 1'b0;
                    end else begin
                        wcnt <= wcnt + WCNT_W'(1);
                    end
                end

                FINISH: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    src1   <= '0;
                    src2   <= '0;
                    dest   <= '0;
                    opcode <= '0;
                    last_q <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
